// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and width helpers for the L1 data-array storage.
package cache_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned INDEX_W_DEF  = 8;
  localparam int unsigned OFFSET_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned words_of(input int unsigned offset_w);
    return 32'd1 << offset_w;
  endfunction

  // A single-way cache still needs a 1-bit way select.
  function automatic int unsigned way_w_of(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int unsigned BYTES_DEF = bytes_of(DATA_W_DEF);
  localparam int unsigned WORDS_DEF = words_of(OFFSET_W_DEF);

endpackage

// File: rtl/cache_data_ram_nway_if.sv
// CPU-side and refill-side signal bundle of the N-way data array.
interface cache_data_ram_nway_if #(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned INDEX_W  = cache_pkg::INDEX_W_DEF,
  parameter int unsigned OFFSET_W = cache_pkg::OFFSET_W_DEF,
  parameter int unsigned DATA_W   = cache_pkg::DATA_W_DEF
);
  localparam int unsigned BYTES  = cache_pkg::bytes_of(DATA_W);
  localparam int unsigned WAY_W  = cache_pkg::way_w_of(WAYS);
  localparam int unsigned ADDR_W = INDEX_W + OFFSET_W;

  logic [ADDR_W-1:0]       addr;
  logic [WAYS-1:0]         data_en;
  logic [WAYS*BYTES-1:0]   data_wen;
  logic [WAYS*DATA_W-1:0]  data_w;
  logic [WAYS*DATA_W-1:0]  data_o;
  logic                    ready;

  logic                    refill_start;
  logic [WAY_W-1:0]        refill_way;
  logic [INDEX_W-1:0]      refill_index;
  logic                    refill_valid;
  logic [DATA_W-1:0]       refill_data;
  logic                    refill_ready;
  logic                    refill_done;

  modport master (
    output addr, data_en, data_wen, data_w,
    output refill_start, refill_way, refill_index, refill_valid, refill_data,
    input  data_o, ready, refill_ready, refill_done
  );

  modport slave (
    input  addr, data_en, data_wen, data_w,
    input  refill_start, refill_way, refill_index, refill_valid, refill_data,
    output data_o, ready, refill_ready, refill_done
  );

endinterface

// File: rtl/cache_data_way.sv
// One way of the data array: byte-masked write-first CPU port with registered read,
// plus a full-word write port used only by the line-refill engine.
module cache_data_way
  import cache_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned ADDR_W = INDEX_W_DEF + OFFSET_W_DEF,
  localparam int unsigned BYTES  = bytes_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [BYTES-1:0]  i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_fill_en,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_data
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;

  // Old word with the enabled byte lanes replaced; also the write-first read value.
  always_comb begin
    w_merged = r_mem[i_addr];
    for (int b = 0; b < int'(BYTES); b++) begin
      if (i_wen[b]) begin
        w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
      end
    end
  end

  // CPU and refill writes are mutually exclusive by construction of the enables.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= w_merged;
    end else if (i_fill_en) begin
      r_mem[i_fill_addr] <= i_fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_data_ram_nway.sv
// N-way L1 data array with a line-refill engine that owns the array while a line streams in.
module cache_data_ram_nway
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS     = 2,
  parameter  int unsigned INDEX_W  = INDEX_W_DEF,
  parameter  int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  localparam int unsigned WAY_W    = way_w_of(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_data_ram_nway_if.slave  bus
);

  localparam int unsigned BYTES  = bytes_of(DATA_W);
  localparam int unsigned WORDS  = words_of(OFFSET_W);
  localparam int unsigned ADDR_W = INDEX_W + OFFSET_W;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [OFFSET_W-1:0]  r_cnt;
  logic [OFFSET_W-1:0]  w_cnt_nxt;
  logic [WAY_W-1:0]     r_way;
  logic [INDEX_W-1:0]   r_index;
  logic                 r_done;
  logic                 w_latch;
  logic                 w_ready;
  logic                 w_fill_we;
  logic [ADDR_W-1:0]    w_fill_addr;

  assign w_ready     = rst & (r_state == ST_IDLE);
  assign w_fill_we   = rst & (r_state == ST_FILL) & bus.refill_valid;
  assign w_fill_addr = {r_index, r_cnt};

  assign bus.ready        = w_ready;
  assign bus.refill_ready = (r_state == ST_FILL);
  assign bus.refill_done  = r_done;

  // Refill sequencing: IDLE -> FILL (one beat per valid word) -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.refill_start) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      ST_FILL: begin
        if (bus.refill_valid) begin
          if (r_cnt == OFFSET_W'(WORDS - 1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + OFFSET_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_way   <= '0;
      r_index <= '0;
    end else if (w_latch) begin
      r_way   <= bus.refill_way;
      r_index <= bus.refill_index;
    end
  end

  for (genvar g = 0; g < int'(WAYS); g++) begin : g_way
    cache_data_way #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .i_en        (w_ready & bus.data_en[g]),
      .i_wen       (bus.data_wen[g*BYTES +: BYTES]),
      .i_addr      (bus.addr),
      .i_wdata     (bus.data_w[g*DATA_W +: DATA_W]),
      .o_rdata     (bus.data_o[g*DATA_W +: DATA_W]),
      .i_fill_en   (w_fill_we & (r_way == WAY_W'(g))),
      .i_fill_addr (w_fill_addr),
      .i_fill_data (bus.refill_data)
    );
  end

endmodule

// File: tb/tb_cache_data_ram_nway.sv
// Randomized and directed bench for cache_data_ram_nway against a behavioural array model.
module tb_cache_data_ram_nway;
  import cache_pkg::*;

  localparam int unsigned WAYS     = 2;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned WORDS    = 1 << OFFSET_W;
  localparam int unsigned AW       = INDEX_W + OFFSET_W;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned WAY_W    = 1;

  logic clk;
  logic rst;

  cache_data_ram_nway_if #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)
  ) bus ();

  cache_data_ram_nway #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: storage contents, last read value per way, and refill progress.
  logic [DATA_W-1:0] m_mem [WAYS][DEPTH];
  logic [DATA_W-1:0] m_do  [WAYS];
  int  m_phase;   // 0 idle, 1 filling, 2 done pulse
  int  m_cnt;
  int  m_way;
  int  m_index;
  bit  m_known;

  int n_checks;
  int n_fail;
  int n_done_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational flags, advance model, check outputs.
  task automatic step(input logic r, input logic [AW-1:0] a, input logic [WAYS-1:0] en,
                      input logic [WAYS*BYTES-1:0] wen, input logic [WAYS*DATA_W-1:0] wd,
                      input logic rs, input logic [WAY_W-1:0] rw, input logic [INDEX_W-1:0] ri,
                      input logic rv, input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] word;
    rst              = r;
    bus.addr         = a;
    bus.data_en      = en;
    bus.data_wen     = wen;
    bus.data_w       = wd;
    bus.refill_start = rs;
    bus.refill_way   = rw;
    bus.refill_index = ri;
    bus.refill_valid = rv;
    bus.refill_data  = rd;
    #1;
    if (m_known) begin
      check("ready", 64'(bus.ready), 64'(r && m_phase == 0));
      check("refill_ready", 64'(bus.refill_ready), 64'(m_phase == 1));
    end
    if (!r) begin
      m_phase = 0;
      m_cnt   = 0;
      for (int w = 0; w < int'(WAYS); w++) m_do[w] = '0;
    end else begin
      case (m_phase)
        0: begin
          for (int w = 0; w < int'(WAYS); w++) begin
            if (en[w]) begin
              word = m_mem[w][a];
              for (int b = 0; b < int'(BYTES); b++)
                if (wen[w*BYTES + b]) word[b*8 +: 8] = wd[w*DATA_W + b*8 +: 8];
              m_mem[w][a] = word;
              m_do[w]     = word;
            end
          end
          if (rs) begin
            m_phase = 1;
            m_cnt   = 0;
            m_way   = int'(rw);
            m_index = int'(ri);
          end
        end
        1: begin
          if (rv) begin
            if (m_way < int'(WAYS)) m_mem[m_way][m_index * WORDS + m_cnt] = rd;
            if (m_cnt == int'(WORDS) - 1) m_phase = 2;
            else m_cnt++;
          end
        end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    for (int w = 0; w < int'(WAYS); w++)
      check($sformatf("data_o%0d", w), 64'(bus.data_o[w*DATA_W +: DATA_W]), 64'(m_do[w]));
    check("refill_done", 64'(bus.refill_done), 64'(m_phase == 2));
    if (bus.refill_done) n_done_seen++;
    m_known = 1'b1;
  endtask

  task automatic cpu(input logic [AW-1:0] a, input logic [WAYS-1:0] en,
                     input logic [WAYS*BYTES-1:0] wen, input logic [WAYS*DATA_W-1:0] wd);
    step(1'b1, a, en, wen, wd, 1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [WAYS*DATA_W-1:0] rnd_data();
    logic [WAYS*DATA_W-1:0] v;
    for (int w = 0; w < int'(WAYS); w++) v[w*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  initial begin
    int k;
    int cyc;
    int done_before;
    clk = 1'b0;
    n_checks = 0; n_fail = 0; n_done_seen = 0;
    m_phase = 0; m_cnt = 0; m_way = 0; m_index = 0; m_known = 1'b0;

    // Reset for two cycles with CPU writes attempted (must be ignored).
    for (int i = 0; i < 2; i++)
      step(1'b0, AW'(i), '1, '1, rnd_data(), 1'b0, '0, '0, 1'b0, '0);
    check("reset_data_o", 64'(bus.data_o), 64'(0));

    // Give every location a known value, both ways per cycle.
    for (int i = 0; i < int'(DEPTH); i++)
      cpu(AW'(i), '1, '1, rnd_data());

    // Byte-masked write into way0 only; way1 holds.
    cpu(12'h010, 2'b01, 8'h05, {32'h0, 32'hAABBCCDD});
    check("byte_lane0", 64'(bus.data_o[7:0]), 64'(8'hDD));
    check("byte_lane2", 64'(bus.data_o[23:16]), 64'(8'hBB));
    cpu(12'h010, 2'b01, 8'h00, rnd_data());

    // Both ways written in one cycle at the same address.
    cpu(12'h020, 2'b11, 8'hFF, {32'h22222222, 32'h11111111});
    check("indep_way0", 64'(bus.data_o[31:0]), 64'(32'h11111111));
    check("indep_way1", 64'(bus.data_o[63:32]), 64'(32'h22222222));

    // Refill way1 set 0x05 with gaps, CPU write to way0 in the start cycle.
    done_before = n_done_seen;
    step(1'b1, 12'h000, 2'b01, 8'hFF, {32'h0, 32'hCAFEF00D}, 1'b1, 1'b1, 8'h05, 1'b0, '0);
    k = 0; cyc = 0;
    while (k < int'(WORDS) && cyc < 200) begin
      logic rv;
      rv = (cyc % 3) != 2;
      step(1'b1, AW'($urandom), '1, '1, rnd_data(), (cyc % 5) == 0, 1'b0, 8'h33,
           rv, DATA_W'(32'h100 + k));
      if (rv) k++;
      cyc++;
    end
    check("refill_beats", 64'(k), 64'(WORDS));
    step(1'b1, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    check("done_pulses", 64'(n_done_seen - done_before), 64'(1));
    cpu(12'h000, 2'b01, 8'h00, '0);
    check("simul_write", 64'(bus.data_o[31:0]), 64'(32'hCAFEF00D));
    for (int i = 0; i < int'(WORDS); i++) begin
      cpu({8'h05, 4'(i)}, 2'b11, 8'h00, '0);
      check($sformatf("refill_word%0d", i), 64'(bus.data_o[63:32]), 64'(32'h100 + i));
    end

    // Reset after eight words of a refill into way0 set 0x09.
    done_before = n_done_seen;
    step(1'b1, '0, '0, '0, '0, 1'b1, 1'b0, 8'h09, 1'b0, '0);
    for (int i = 0; i < 8; i++)
      step(1'b1, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1, DATA_W'(32'h200 + i));
    step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hDEAD0000);
    step(1'b1, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    check("mid_reset_ready", 64'(bus.ready), 64'(1));
    for (int i = 0; i < int'(WORDS); i++) begin
      cpu({8'h09, 4'(i)}, 2'b11, 8'h00, '0);
      if (i < 8) check($sformatf("partial_word%0d", i), 64'(bus.data_o[31:0]), 64'(32'h200 + i));
    end
    check("mid_reset_no_done", 64'(n_done_seen - done_before), 64'(0));

    // Random traffic over a small address window so refills and CPU writes collide.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0, AW'($urandom_range(0, 63)), WAYS'($urandom),
           (WAYS*BYTES)'($urandom), rnd_data(), $urandom_range(0, 19) == 0,
           WAY_W'($urandom), INDEX_W'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           DATA_W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
